// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// pipe_pkg : shared control-bundle type and constants for the ID/EX pipeline.
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    typedef struct packed {
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] ALUOp;
        logic       Branch;
    } ctrl_t;

    localparam ctrl_t      CTRL_NOP  = '0;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
//------------------------------------------------------------------------------
// load_use_detect : combinational load-use hazard check between EX and ID.
// Rev 1.0         : initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  ctrl_t            id_ctrl,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    output logic             hazard
);

    logic w_rs1_used;
    logic w_rs2_used;
    logic w_ex_load;
    logic w_unused_ctrl;

    // LUI has no rs1; rs2 is read by R-type/branch ops and as store data.
    assign w_rs1_used = (id_ctrl.ALUOp != ALUOP_LUI);
    assign w_rs2_used = !id_ctrl.ALUSrc || id_ctrl.MemWrite;
    assign w_ex_load  = ex_valid && ex_memread && (ex_rd != '0);

    assign hazard = w_ex_load && id_valid &&
                    ((w_rs1_used && (id_rs1 == ex_rd)) ||
                     (w_rs2_used && (id_rs2 == ex_rd)));

    assign w_unused_ctrl = ^{id_ctrl.MemtoReg, id_ctrl.RegWrite,
                             id_ctrl.MemRead, id_ctrl.Branch};

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with load-use bubble, hold and flush.
//               Optional performance counters when ID_EX_PERF_CNT_EN is defined.
// Rev 1.0     : initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              hold,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [2:0]        ex_funct3,
`ifdef ID_EX_PERF_CNT_EN
    output logic [6:0]        ex_funct7,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`else
    output logic [6:0]        ex_funct7
`endif
);

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs1;
    logic [REG_W-1:0]  r_rs2;
    logic [REG_W-1:0]  r_rd;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic              w_load_use;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_valid   (r_valid),
        .ex_memread (r_ctrl.MemRead),
        .ex_rd      (r_rd),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .hazard     (w_load_use)
    );

    // A flushed ID instruction is discarded, so it must not freeze the front end.
    assign hazard_stall = w_load_use && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_ctrl   <= CTRL_NOP;
            r_pc     <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_funct3 <= '0;
            r_funct7 <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else if (hold) begin
            r_valid <= r_valid;
        end else if (w_load_use) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else begin
            r_valid  <= id_valid;
            r_ctrl   <= id_valid ? id_ctrl : CTRL_NOP;
            r_pc     <= id_pc;
            r_rd1    <= id_rd1;
            r_rd2    <= id_rd2;
            r_imm    <= id_imm;
            r_rs1    <= id_rs1;
            r_rs2    <= id_rs2;
            r_rd     <= id_rd;
            r_funct3 <= id_funct3;
            r_funct7 <= id_funct7;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Counters are frozen under hold, and flush overrides a coincident hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!hold) begin
            if (flush) begin
                if (id_valid && (r_flush_cnt != 32'hFFFF_FFFF))
                    r_flush_cnt <= r_flush_cnt + 32'd1;
            end else if (w_load_use && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

    assign ex_valid  = r_valid;
    assign ex_ctrl   = r_ctrl;
    assign ex_pc     = r_pc;
    assign ex_rd1    = r_rd1;
    assign ex_rd2    = r_rd2;
    assign ex_imm    = r_imm;
    assign ex_rs1    = r_rs1;
    assign ex_rs2    = r_rs2;
    assign ex_rd     = r_rd;
    assign ex_funct3 = r_funct3;
    assign ex_funct7 = r_funct7;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// tb_id_ex_stage : table-driven self-checking bench for id_ex_stage.
// Rev 1.0        : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

    localparam logic [7:0] LW   = 8'hF0;
    localparam logic [7:0] ADD  = 8'h24;
    localparam logic [7:0] ADDI = 8'hA0;
    localparam logic [7:0] LUI  = 8'hA6;
    localparam logic [7:0] SW   = 8'h88;

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
        logic        hold, flush;
        logic        e_stall;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [4:0]  e_rd, e_rs1, e_rs2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [7:0]  id_ctrl;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        hold, flush;
    logic        hazard_stall, ex_valid;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_pc        (id_pc),
        .id_rd1       (id_rd1),
        .id_rd2       (id_rd2),
        .id_imm       (id_imm),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_funct3    (id_funct3),
        .id_funct7    (id_funct7),
        .hold         (hold),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_pc        (ex_pc),
        .ex_rd1       (ex_rd1),
        .ex_rd2       (ex_rd2),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_funct3    (ex_funct3),
`ifdef ID_EX_PERF_CNT_EN
        .ex_funct7    (ex_funct7),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
`else
        .ex_funct7    (ex_funct7)
`endif
    );

    // Operand payloads are derived from the PC so each instruction is distinct.
    function automatic logic [31:0] f_rd1(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction
    function automatic logic [31:0] f_rd2(input logic [31:0] pc);
        return pc ^ 32'h0000_BEEF;
    endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d, input logic [31:0] pc,
                         input logic h, input logic f);
        id_valid  = v;
        id_ctrl   = c;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = d;
        id_pc     = pc;
        id_rd1    = f_rd1(pc);
        id_rd2    = f_rd2(pc);
        id_imm    = f_imm(pc);
        id_funct3 = pc[4:2];
        id_funct7 = pc[8:2];
        hold      = h;
        flush     = f;
    endtask

    task automatic add_vec(input logic v, input logic [7:0] c, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] d, input logic [31:0] pc,
                           input logic h, input logic f, input logic es, input logic ev,
                           input logic [7:0] ec, input logic cd, input logic [31:0] epc,
                           input logic [4:0] erd, input logic [4:0] ers1, input logic [4:0] ers2);
        vec_t t;
        t.valid = v; t.ctrl = c; t.rs1 = r1; t.rs2 = r2; t.rd = d; t.pc = pc;
        t.hold = h; t.flush = f; t.e_stall = es; t.e_valid = ev; t.e_ctrl = ec;
        t.chk_data = cd; t.e_pc = epc; t.e_rd = erd; t.e_rs1 = ers1; t.e_rs2 = ers2;
        vecs.push_back(t);
    endtask

    initial begin
        // valid ctrl rs1 rs2 rd pc hold flush | stall valid ctrl chk pc rd rs1 rs2
        add_vec(1, LW,   1, 0, 5, 32'h00, 0, 0,  0, 1, LW,   1, 32'h00, 5, 1, 0);
        add_vec(1, ADD,  5, 7, 6, 32'h04, 0, 0,  1, 0, 8'h0, 0, 32'h00, 0, 0, 0);
        add_vec(1, ADD,  5, 7, 6, 32'h04, 0, 0,  0, 1, ADD,  1, 32'h04, 6, 5, 7);
        add_vec(1, LW,   1, 0, 0, 32'h08, 0, 0,  0, 1, LW,   1, 32'h08, 0, 1, 0);
        add_vec(1, ADD,  0, 0, 6, 32'h0C, 0, 0,  0, 1, ADD,  1, 32'h0C, 6, 0, 0);
        add_vec(1, LW,   1, 0, 5, 32'h10, 0, 0,  0, 1, LW,   1, 32'h10, 5, 1, 0);
        add_vec(1, LUI,  5, 5, 5, 32'h14, 0, 0,  0, 1, LUI,  1, 32'h14, 5, 5, 5);
        add_vec(1, LW,   1, 0, 5, 32'h18, 0, 0,  0, 1, LW,   1, 32'h18, 5, 1, 0);
        add_vec(1, ADDI, 9, 5, 8, 32'h1C, 0, 0,  0, 1, ADDI, 1, 32'h1C, 8, 9, 5);
        add_vec(1, LW,   1, 0, 5, 32'h20, 0, 0,  0, 1, LW,   1, 32'h20, 5, 1, 0);
        add_vec(1, SW,   5, 9, 0, 32'h24, 0, 0,  1, 0, 8'h0, 0, 32'h00, 0, 0, 0);
        add_vec(1, SW,   5, 9, 0, 32'h24, 0, 0,  0, 1, SW,   1, 32'h24, 0, 5, 9);
        add_vec(1, LW,   1, 0, 5, 32'h28, 0, 0,  0, 1, LW,   1, 32'h28, 5, 1, 0);
        add_vec(1, SW,   1, 5, 0, 32'h2C, 0, 0,  1, 0, 8'h0, 0, 32'h00, 0, 0, 0);
        add_vec(1, LW,   1, 0, 5, 32'h30, 0, 0,  0, 1, LW,   1, 32'h30, 5, 1, 0);
        add_vec(1, ADD,  5, 7, 6, 32'h34, 0, 1,  0, 0, 8'h0, 0, 32'h00, 0, 0, 0);
        add_vec(1, LW,   1, 0, 5, 32'h38, 0, 0,  0, 1, LW,   1, 32'h38, 5, 1, 0);
        add_vec(1, ADD,  5, 7, 6, 32'h3C, 1, 1,  0, 0, 8'h0, 0, 32'h00, 0, 0, 0);
        add_vec(1, LW,   1, 0, 5, 32'h40, 0, 0,  0, 1, LW,   1, 32'h40, 5, 1, 0);
        for (int k = 0; k < 3; k++)
            add_vec(1, ADD, 5, 7, 6, 32'h44, 1, 0, 1, 1, LW, 1, 32'h40, 5, 1, 0);
        add_vec(1, ADD,  5, 7, 6, 32'h44, 0, 0,  1, 0, 8'h0, 0, 32'h00, 0, 0, 0);
        add_vec(1, ADD,  5, 7, 6, 32'h44, 0, 0,  0, 1, ADD,  1, 32'h44, 6, 5, 7);
        add_vec(0, ADD,  5, 7, 7, 32'h48, 0, 0,  0, 0, 8'h0, 1, 32'h48, 7, 5, 7);
        add_vec(1, LW,   1, 0, 5, 32'h4C, 0, 0,  0, 1, LW,   1, 32'h4C, 5, 1, 0);
        add_vec(0, ADD,  5, 7, 6, 32'h50, 0, 0,  0, 0, 8'h0, 1, 32'h50, 6, 5, 7);
        add_vec(1, LW,   1, 0, 5, 32'h54, 0, 0,  0, 1, LW,   1, 32'h54, 5, 1, 0);
        add_vec(0, ADD,  5, 7, 6, 32'h58, 0, 1,  0, 0, 8'h0, 0, 32'h00, 0, 0, 0);

        // Reset state, then an asynchronous mid-cycle reset while EX is valid.
        reset = 1'b1;
        drive(0, 8'h0, 0, 0, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ctrl",  {24'd0, ex_ctrl}, 32'd0);
        check("rst_pc",    ex_pc, 32'd0);
        check("rst_rd1",   ex_rd1, 32'd0);
        reset = 1'b0;
        drive(1, ADD, 2, 3, 4, 32'h100, 0, 0);
        @(posedge clk); #1;
        check("cap_valid", {31'd0, ex_valid}, 32'd1);
        check("cap_pc",    ex_pc, 32'h100);
        @(negedge clk);
        drive(1, ADD, 2, 3, 4, 32'h104, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, ex_valid}, 32'd0);
        check("async_ctrl",  {24'd0, ex_ctrl}, 32'd0);
        check("async_pc",    ex_pc, 32'd0);
        check("async_rd",    {27'd0, ex_rd}, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rel_valid", {31'd0, ex_valid}, 32'd1);
        check("rel_pc",    ex_pc, 32'h104);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].pc, vecs[i].hold, vecs[i].flush);
            #1;
            check($sformatf("v%0d_stall", i), {31'd0, hazard_stall}, {31'd0, vecs[i].e_stall});
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d_ctrl", i), {24'd0, ex_ctrl}, {24'd0, vecs[i].e_ctrl});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_pc", i),  ex_pc, vecs[i].e_pc);
                check($sformatf("v%0d_rd", i),  {27'd0, ex_rd},  {27'd0, vecs[i].e_rd});
                check($sformatf("v%0d_rs1", i), {27'd0, ex_rs1}, {27'd0, vecs[i].e_rs1});
                check($sformatf("v%0d_rs2", i), {27'd0, ex_rs2}, {27'd0, vecs[i].e_rs2});
                check($sformatf("v%0d_rd1", i), ex_rd1, f_rd1(vecs[i].e_pc));
                check($sformatf("v%0d_rd2", i), ex_rd2, f_rd2(vecs[i].e_pc));
                check($sformatf("v%0d_imm", i), ex_imm, f_imm(vecs[i].e_pc));
                check($sformatf("v%0d_f3", i), {29'd0, ex_funct3}, {29'd0, vecs[i].e_pc[4:2]});
                check($sformatf("v%0d_f7", i), {25'd0, ex_funct7}, {25'd0, vecs[i].e_pc[8:2]});
            end
        end

`ifdef ID_EX_PERF_CNT_EN
        // Bubbles at v1, v10, v13, v22; only v15 is a counted valid flush (v17 is under hold).
        check("bubble_cnt", bubble_cnt, 32'd4);
        check("flush_cnt",  flush_cnt,  32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
